// File: rtl/seq_player.sv
// Plays len register-file entries as timed tones; optional abort input via SEQ_PLAYER_ABORT_EN.
// Each element takes 1+ON_CYCLES+OFF_CYCLES cycles; start is ignored while busy.
module seq_player #(
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [4:0] len,
`ifdef SEQ_PLAYER_ABORT_EN
   input  logic       abort,
`endif
   output logic [3:0] rd_sel,
   input  logic [2:0] rd_data,
   output logic [2:0] tone_idx,
   output logic       tone_valid,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ON,
      S_OFF,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       len_q;
   logic             last_elem;
   logic             abort_req;

`ifdef SEQ_PLAYER_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // rd_sel doubles as the element index, so it never needs to go past len-1.
   assign last_elem = ({1'b0, rd_sel} == (len_q - 5'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rd_sel     <= '0;
         tone_idx   <= '0;
         tone_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cnt        <= '0;
         len_q      <= '0;
      end else if (abort_req && (state != S_IDLE)) begin
         state      <= S_IDLE;
         tone_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len == 5'd0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state  <= S_FETCH;
                     rd_sel <= '0;
                     len_q  <= (len > 5'd16) ? 5'd16 : len;
                  end
               end
            end
            S_FETCH: begin
               tone_idx   <= rd_data;
               tone_valid <= 1'b1;
               cnt        <= ON_LAST;
               state      <= S_ON;
            end
            S_ON: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  tone_valid <= 1'b0;
                  cnt        <= OFF_LAST;
                  state      <= S_OFF;
               end
            end
            S_OFF: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (last_elem) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  rd_sel <= rd_sel + 4'd1;
                  state  <= S_FETCH;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_player.sv
// Randomized bench for seq_player against a per-cycle timeline model of the playback.
module tb_seq_player;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [4:0] len;
   logic [3:0] rd_sel;
   logic [2:0] rd_data;
   logic [2:0] tone_idx;
   logic       tone_valid;
   logic       busy;
   logic       done;
`ifdef SEQ_PLAYER_ABORT_EN
   logic       abort;
`endif

   logic [2:0] mem [16];
   int passed;
   int total;

   assign rd_data = mem[rd_sel];

   seq_player dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
`ifdef SEQ_PLAYER_ABORT_EN
      .abort     (abort),
`endif
      .rd_sel    (rd_sel),
      .rd_data   (rd_data),
      .tone_idx  (tone_idx),
      .tone_valid(tone_valid),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic randomize_mem();
      for (int i = 0; i < 16; i++) mem[i] = 3'($urandom_range(0, 7));
   endtask

   // Model: after the t-th edge following the start edge, element k=t/7 is in
   // phase p=t%7 (0 fetch, 1..4 tone on, 5..6 gap); done lands on edge 7*n.
   task automatic run_and_check_playback(input int l, input int restart_at);
      int n, k, p, done_seen;
      logic e_busy, e_done, e_valid;
      n = (l > 16) ? 16 : l;
      done_seen = 0;
      @(negedge clk);
      start = 1'b1;
      len   = 5'(l);
      @(posedge clk);
      for (int t = 0; t <= 7 * n + 3; t++) begin
         @(negedge clk);
         start = (t == restart_at);
         k = t / 7;
         p = t % 7;
         e_busy  = (t <= 7 * n);
         e_done  = (t == 7 * n);
         e_valid = (t < 7 * n) && (p >= 1) && (p <= 4);
         if (done) done_seen++;
         total++;
         if (busy !== e_busy) $display("FAIL busy len=%0d t=%0d got %b want %b", l, t, busy, e_busy);
         else passed++;
         total++;
         if (done !== e_done) $display("FAIL done len=%0d t=%0d got %b want %b", l, t, done, e_done);
         else passed++;
         total++;
         if (tone_valid !== e_valid) $display("FAIL tone_valid len=%0d t=%0d got %b want %b", l, t, tone_valid, e_valid);
         else passed++;
         if (n > 0) begin
            total++;
            if (rd_sel !== 4'((t < 7 * n) ? k : n - 1))
               $display("FAIL rd_sel len=%0d t=%0d got %0d want %0d", l, t, rd_sel, (t < 7 * n) ? k : n - 1);
            else passed++;
            if ((t < 7 * n && p >= 1) || t >= 7 * n) begin
               total++;
               if (tone_idx !== mem[(t < 7 * n) ? k : n - 1])
                  $display("FAIL tone_idx len=%0d t=%0d got %0d want %0d", l, t, tone_idx, mem[(t < 7 * n) ? k : n - 1]);
               else passed++;
            end
         end
      end
      total++;
      if (done_seen !== 1) $display("FAIL done_count len=%0d got %0d want 1", l, done_seen);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      len   = 5'd0;
`ifdef SEQ_PLAYER_ABORT_EN
      abort = 1'b0;
`endif
      #12;
      total++;
      if ({rd_sel, tone_idx, tone_valid, busy, done} !== 10'd0)
         $display("FAIL reset_state got %b want 0", {rd_sel, tone_idx, tone_valid, busy, done});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) $display("FAIL idle_after_reset busy got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_basic();
      mem[0] = 3'd5; mem[1] = 3'd2; mem[2] = 3'd7;
      run_and_check_playback(3, -1);
   endtask

   task automatic test_zero_len();
      run_and_check_playback(0, -1);
   endtask

   task automatic test_clamp();
      randomize_mem();
      run_and_check_playback(20, -1);
      total++;
      if (rd_sel !== 4'd15) $display("FAIL clamp_last_sel got %0d want 15", rd_sel);
      else passed++;
   endtask

   task automatic test_back_to_back_start();
      randomize_mem();
      run_and_check_playback(3, 9);
   endtask

   task automatic test_reset_mid_play();
      int dones;
      randomize_mem();
      dones = 0;
      @(negedge clk);
      start = 1'b1;
      len   = 5'd3;
      @(posedge clk);
      for (int t = 0; t <= 9; t++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) dones++;
      end
      total++;
      if (tone_valid !== 1'b1) $display("FAIL pre_reset_tone got %b want 1", tone_valid);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({rd_sel, tone_idx, tone_valid, busy, done} !== 10'd0)
         $display("FAIL async_reset got %b want 0", {rd_sel, tone_idx, tone_valid, busy, done});
      else passed++;
      repeat (3) begin
         @(negedge clk);
         if (done) dones++;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done) dones++;
      end
      total++;
      if (dones !== 0 || busy !== 1'b0)
         $display("FAIL reset_abandon dones=%0d busy=%b want 0 0", dones, busy);
      else passed++;
      run_and_check_playback(3, -1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         randomize_mem();
         run_and_check_playback(int'($urandom_range(0, 20)), -1);
      end
   endtask

`ifdef SEQ_PLAYER_ABORT_EN
   task automatic test_abort();
      int dones;
      randomize_mem();
      dones = 0;
      @(negedge clk);
      start = 1'b1;
      len   = 5'd3;
      @(posedge clk);
      for (int t = 0; t <= 5; t++) begin
         @(negedge clk);
         start = 1'b0;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if ({tone_valid, busy, done} !== 3'b000)
         $display("FAIL abort_idle got %b want 000", {tone_valid, busy, done});
      else passed++;
      repeat (25) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      total++;
      if (dones !== 0) $display("FAIL abort_stays_idle got %0d want 0", dones);
      else passed++;
   endtask
`endif

   initial begin
      passed = 0;
      total  = 0;
      for (int i = 0; i < 16; i++) mem[i] = 3'd0;
      test_reset();
      test_basic();
      test_zero_len();
      test_clamp();
      test_back_to_back_start();
      test_reset_mid_play();
      test_random();
`ifdef SEQ_PLAYER_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter ON_CYCLES, default 4: clock cycles each tone is displayed; SHALL be >= 1.
REQ-002 Parameter OFF_CYCLES, default 2: clock cycles of blank gap after each tone; SHALL be >= 1.
REQ-003 Parameter CNT_W, default 8: width of the internal dwell counter; SHALL hold max(ON_CYCLES, OFF_CYCLES) - 1.
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-006 start  input  1  request playback; sampled only in IDLE.
REQ-007 len  input  5  number of sequence elements to play, 0..16; sampled with start.
REQ-008 rd_sel  output  4  read address to the sequence register file.
REQ-009 rd_data  input  3  element returned by the register file; combinational in rd_sel with same-cycle validity.
REQ-010 tone_idx  output  3  current tone/LED index.
REQ-011 tone_valid  output  1  high while tone_idx is being displayed.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle pulse at the end of playback.

Function
REQ-014 FSM states: IDLE, FETCH, ON, OFF, DONE; one state per cycle, registered outputs only.
REQ-015 IDLE: start=1 with len>=1 -> rd_sel<=0, element index<=0, latch len (values >16 clamped to 16), go to FETCH.
REQ-016 IDLE: start=1 with len=0 -> go directly to DONE; tone_valid stays 0.
REQ-017 FETCH: tone_idx<=rd_data, tone_valid<=1, counter<=ON_CYCLES-1, go to ON.
REQ-018 ON: counter!=0 -> decrement; counter=0 -> tone_valid<=0, counter<=OFF_CYCLES-1, go to OFF; tone_valid therefore stays high exactly ON_CYCLES cycles.
REQ-019 OFF: counter!=0 -> decrement; counter=0 and last element -> DONE; otherwise index+1, rd_sel+1, go to FETCH.
REQ-020 Each element SHALL occupy exactly 1+ON_CYCLES+OFF_CYCLES cycles; rd_sel SHALL be stable for that entire span.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy SHALL fall in the same cycle that done falls.
REQ-022 start while busy=1 SHALL be ignored, with no restart or queueing.
REQ-023 tone_idx SHALL hold its last value when tone_valid=0.
REQ-024 rd_sel SHALL never exceed 15; the index of the 16th element is 15, with no wrap to 0 during playback.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, rd_sel=0, tone_idx=0, tone_valid=0, busy=0, done=0, counter=0, independent of clk.
REQ-026 Reset mid-playback SHALL abandon the sequence with no done pulse; after release, the block SHALL wait in IDLE for a fresh start.

Configuration
REQ-027 Macro SEQ_PLAYER_ABORT_EN defined: adds input abort (1 bit); abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with tone_valid=0, busy=0, and no done pulse. abort has priority over all other transitions; abort in IDLE has no effect.
REQ-028 Macro not defined: no abort port exists, and playback always runs to DONE unless reset.

Verification
REQ-029 Defaults; file holds 5,2,7 at addresses 0..2; start with len=3 -> tone_idx 5,2,7, each tone_valid high 4 cycles with 2-cycle gaps; done pulses in cycle 21 after the start edge.
REQ-030 start with len=0 -> done pulse on the next cycle; tone_valid never asserts; busy high for 1 cycle.
REQ-031 start with len=20 -> exactly 16 tones, rd_sel 0..15, last element read at rd_sel=15, then done.
REQ-032 start re-pulsed during the second tone of a len=3 run -> playback unaffected, single done pulse.
REQ-033 rst_n low during ON of element 1 -> all outputs 0 asynchronously, no done; new start after release plays from rd_sel=0.
REQ-034 With SEQ_PLAYER_ABORT_EN: abort in OFF of element 0 -> IDLE next edge, busy=0, no done; without the macro, the bench confirms the port is absent.
